// File: rtl/ooo_types.sv
// Shared types for the out-of-order back end: renamed instruction and RS entry layouts.
// Field widths are fixed here so every stage agrees on tag and payload sizes.
package ooo_types;

  localparam int PHYS_REG_BITS = 7;
  localparam int ARCH_REG_BITS = 5;
  localparam int ROB_TAG_BITS  = 5;
  localparam int XLEN          = 32;

  typedef struct packed {
    logic                     valid;
    logic [XLEN-1:0]          pc;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [PHYS_REG_BITS-1:0] prd_old;
    logic [ARCH_REG_BITS-1:0] ard;
    logic [XLEN-1:0]          immediate;
    logic [3:0]               alu_op;
    logic [1:0]               fu_type;
    logic                     alu_src;
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
    logic                     is_branch;
    logic [ROB_TAG_BITS-1:0]  rob_tag;
  } renamed_instr_t;

  typedef struct packed {
    logic                     valid;
    logic                     prs1_ready;
    logic                     prs2_ready;
    logic [XLEN-1:0]          pc;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [PHYS_REG_BITS-1:0] prd_old;
    logic [ARCH_REG_BITS-1:0] ard;
    logic [XLEN-1:0]          immediate;
    logic [3:0]               alu_op;
    logic [1:0]               fu_type;
    logic                     alu_src;
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
    logic                     is_branch;
    logic [ROB_TAG_BITS-1:0]  rob_tag;
  } rs_entry_t;

endpackage

// File: rtl/ooo_reservation_station_if.sv
// Dispatch / issue / wakeup bundle of the reservation station.
// master = surrounding pipeline, slave = the reservation station itself.
interface ooo_reservation_station_if #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = $clog2(RS_SIZE)
);
  import ooo_types::*;

  logic                     dispatch_en;
  renamed_instr_t           dispatch_instr;
  logic                     full;
  logic [IDX_W-1:0]         alloc_idx;
  logic                     alloc_valid;
  logic                     issue_en;
  rs_entry_t                issue_entry;
  logic [IDX_W-1:0]         issue_idx;
  logic                     eu_ready;
  logic                     wb_en;
  logic [PHYS_REG_BITS-1:0] wb_prd;
  logic                     flush;

  modport master (
    output dispatch_en, dispatch_instr, eu_ready, wb_en, wb_prd, flush,
    input  full, alloc_idx, alloc_valid, issue_en, issue_entry, issue_idx
  );

  modport slave (
    input  dispatch_en, dispatch_instr, eu_ready, wb_en, wb_prd, flush,
    output full, alloc_idx, alloc_valid, issue_en, issue_entry, issue_idx
  );

endinterface

// File: rtl/ooo_reservation_station.sv
// Out-of-order issue queue: lowest free slot allocates, lowest ready slot issues one per cycle.
// Issue is registered (dispatch-to-issue two edges); upstream stalls on full, eu_ready low holds entries.
module ooo_reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input logic                      clk,
  input logic                      rst,
  ooo_reservation_station_if.slave rs
);
  import ooo_types::*;

  rs_entry_t            entries [RS_SIZE];
  logic [RS_SIZE-1:0]   valid_vec;
  logic [RS_SIZE-1:0]   ready_vec;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 alloc_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_found;
  logic                 do_dispatch;
  logic                 do_issue;
  rs_entry_t            new_entry;
  rs_entry_t            issue_entry_q;
  logic [IDX_W-1:0]     issue_idx_q;
  logic                 issue_en_q;
  logic                 unused_instr_valid;

  assign unused_instr_valid = rs.dispatch_instr.valid;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = entries[i].valid;
      ready_vec[i] = entries[i].valid && entries[i].prs1_ready && entries[i].prs2_ready;
    end
  end

  // Priority encoders: scanning downward leaves the lowest matching index.
  always_comb begin
    alloc_idx   = '0;
    alloc_valid = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        alloc_idx   = IDX_W'(i);
        alloc_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign do_dispatch = rs.dispatch_en && alloc_valid && !rs.flush;
  assign do_issue    = rs.eu_ready && sel_found && !rs.flush;

  // No busy table feeds this block, so operands arrive ready; a same-edge wakeup is folded in anyway.
  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.prs1_ready = 1'b1 | (rs.wb_en && (rs.dispatch_instr.prs1 == rs.wb_prd));
    new_entry.prs2_ready = 1'b1 | (rs.wb_en && (rs.dispatch_instr.prs2 == rs.wb_prd));
    new_entry.pc         = rs.dispatch_instr.pc;
    new_entry.prs1       = rs.dispatch_instr.prs1;
    new_entry.prs2       = rs.dispatch_instr.prs2;
    new_entry.prd        = rs.dispatch_instr.prd;
    new_entry.prd_old    = rs.dispatch_instr.prd_old;
    new_entry.ard        = rs.dispatch_instr.ard;
    new_entry.immediate  = rs.dispatch_instr.immediate;
    new_entry.alu_op     = rs.dispatch_instr.alu_op;
    new_entry.fu_type    = rs.dispatch_instr.fu_type;
    new_entry.alu_src    = rs.dispatch_instr.alu_src;
    new_entry.mem_read   = rs.dispatch_instr.mem_read;
    new_entry.mem_write  = rs.dispatch_instr.mem_write;
    new_entry.reg_write  = rs.dispatch_instr.reg_write;
    new_entry.is_branch  = rs.dispatch_instr.is_branch;
    new_entry.rob_tag    = rs.dispatch_instr.rob_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries[i] <= '0;
      end
    end else if (rs.flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (rs.wb_en && entries[i].valid && (entries[i].prs1 == rs.wb_prd)) begin
          entries[i].prs1_ready <= 1'b1;
        end
        if (rs.wb_en && entries[i].valid && (entries[i].prs2 == rs.wb_prd)) begin
          entries[i].prs2_ready <= 1'b1;
        end
      end
      if (do_issue) begin
        entries[sel_idx].valid <= 1'b0;
      end
      // alloc_idx is a free slot and sel_idx a valid one, so these never collide.
      if (do_dispatch) begin
        entries[alloc_idx] <= new_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_en_q    <= 1'b0;
      issue_idx_q   <= '0;
      issue_entry_q <= '0;
    end else if (do_issue) begin
      issue_en_q    <= 1'b1;
      issue_idx_q   <= sel_idx;
      issue_entry_q <= entries[sel_idx];
    end else begin
      issue_en_q    <= 1'b0;
    end
  end

  assign rs.full        = !alloc_valid;
  assign rs.alloc_valid = alloc_valid;
  assign rs.alloc_idx   = alloc_idx;
  assign rs.issue_en    = issue_en_q;
  assign rs.issue_idx   = issue_idx_q;
  assign rs.issue_entry = issue_entry_q;

endmodule

// File: tb/tb_ooo_reservation_station.sv
// Scenario bench for ooo_reservation_station; issued entries are checked against a queue of expected (slot, prd).
module tb_ooo_reservation_station;
  import ooo_types::*;

  localparam int RS_SIZE = 8;
  localparam int IDX_W   = $clog2(RS_SIZE);

  typedef struct {
    int idx;
    int prd;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  ooo_reservation_station_if #(.RS_SIZE(RS_SIZE)) bus ();

  ooo_reservation_station #(.RS_SIZE(RS_SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.issue_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_issue got idx=%0d prd=%0d want no issue",
                 bus.issue_idx, bus.issue_entry.prd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(bus.issue_idx) !== e.idx || int'(bus.issue_entry.prd) !== e.prd ||
            bus.issue_entry.valid !== 1'b1) begin
          n_err++;
          $display("FAIL sb_issue got idx=%0d prd=%0d valid=%b want idx=%0d prd=%0d valid=1",
                   bus.issue_idx, bus.issue_entry.prd, bus.issue_entry.valid, e.idx, e.prd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int prd);
    renamed_instr_t ri;
    ri           = '0;
    ri.valid     = 1'b1;
    ri.pc        = 32'h1000 + 32'(prd * 4);
    ri.prs1      = PHYS_REG_BITS'(prd + 1);
    ri.prs2      = PHYS_REG_BITS'(prd + 2);
    ri.prd       = PHYS_REG_BITS'(prd);
    ri.ard       = ARCH_REG_BITS'(prd);
    ri.reg_write = 1'b1;
    ri.rob_tag   = ROB_TAG_BITS'(prd);
    bus.dispatch_instr = ri;
  endtask

  task automatic push_exp(input int idx, input int prd);
    exp_t e;
    e.idx = idx;
    e.prd = prd;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    bus.dispatch_en    = 1'b0;
    bus.dispatch_instr = '0;
    bus.eu_ready       = 1'b0;
    bus.wb_en          = 1'b0;
    bus.wb_prd         = '0;
    bus.flush          = 1'b0;
    #12;
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus.full); end
    n_cmp++; if (bus.alloc_valid !== 1'b1) begin n_err++; $display("FAIL reset_alloc_valid got %b want 1", bus.alloc_valid); end
    n_cmp++; if (bus.alloc_idx !== IDX_W'(0)) begin n_err++; $display("FAIL reset_alloc_idx got %0d want 0", bus.alloc_idx); end
    n_cmp++; if (bus.issue_en !== 1'b0) begin n_err++; $display("FAIL reset_issue_en got %b want 0", bus.issue_en); end
    n_cmp++; if (bus.issue_idx !== IDX_W'(0)) begin n_err++; $display("FAIL reset_issue_idx got %0d want 0", bus.issue_idx); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    bus.eu_ready    = 1'b1;
    set_instr(32);
    bus.dispatch_en = 1'b1;
    push_exp(0, 32);
    tick();
    bus.dispatch_en = 1'b0;
    n_cmp++; if (bus.alloc_idx !== IDX_W'(1)) begin n_err++; $display("FAIL single_alloc_after_dispatch got %0d want 1", bus.alloc_idx); end
    n_cmp++; if (bus.issue_en !== 1'b0) begin n_err++; $display("FAIL single_no_early_issue got %b want 0", bus.issue_en); end
    tick();
    n_cmp++; if (bus.issue_en !== 1'b1) begin n_err++; $display("FAIL single_issue_en got %b want 1", bus.issue_en); end
    n_cmp++; if (bus.issue_entry.prd !== PHYS_REG_BITS'(32)) begin n_err++; $display("FAIL single_prd got %0d want 32", bus.issue_entry.prd); end
    n_cmp++; if (bus.alloc_idx !== IDX_W'(0)) begin n_err++; $display("FAIL single_slot_freed got %0d want 0", bus.alloc_idx); end
    tick();
    n_cmp++; if (bus.issue_en !== 1'b0) begin n_err++; $display("FAIL single_issue_drop got %b want 0", bus.issue_en); end
  endtask

  task automatic test_fill_and_drain();
    bus.eu_ready = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      set_instr(40 + i);
      bus.dispatch_en = 1'b1;
      bus.wb_en       = (i % 3 == 0);
      bus.wb_prd      = PHYS_REG_BITS'(41 + i);
      push_exp(i, 40 + i);
      tick();
      n_cmp++;
      if (bus.alloc_idx !== IDX_W'((i + 1) % RS_SIZE)) begin
        n_err++; $display("FAIL fill_alloc_idx step=%0d got %0d want %0d", i, bus.alloc_idx, (i + 1) % RS_SIZE);
      end
    end
    bus.wb_en = 1'b0;
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", bus.full); end
    n_cmp++; if (bus.alloc_valid !== 1'b0) begin n_err++; $display("FAIL fill_alloc_valid got %b want 0", bus.alloc_valid); end
    set_instr(99);
    tick();
    bus.dispatch_en = 1'b0;
    n_cmp++; if (bus.full !== 1'b1 || bus.issue_en !== 1'b0) begin n_err++; $display("FAIL fill_ninth_ignored got full=%b issue_en=%b want full=1 issue_en=0", bus.full, bus.issue_en); end
    bus.eu_ready = 1'b1;
    tick();
    n_cmp++; if (bus.full !== 1'b0 || bus.alloc_idx !== IDX_W'(0)) begin n_err++; $display("FAIL drain_first_frees got full=%b alloc_idx=%0d want full=0 alloc_idx=0", bus.full, bus.alloc_idx); end
    for (int i = 1; i < RS_SIZE; i++) begin
      tick();
      n_cmp++;
      if (bus.issue_en !== 1'b1 || bus.issue_idx !== IDX_W'(i)) begin
        n_err++; $display("FAIL drain_order step=%0d got en=%b idx=%0d want en=1 idx=%0d", i, bus.issue_en, bus.issue_idx, i);
      end
    end
    tick();
    n_cmp++; if (bus.issue_en !== 1'b0) begin n_err++; $display("FAIL drain_empty_issue got %b want 0", bus.issue_en); end
  endtask

  task automatic test_hold();
    bus.eu_ready    = 1'b0;
    set_instr(50);
    bus.dispatch_en = 1'b1;
    push_exp(0, 50);
    tick();
    bus.dispatch_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.issue_en !== 1'b0) begin n_err++; $display("FAIL hold_no_issue got %b want 0", bus.issue_en); end
    n_cmp++; if (bus.alloc_idx !== IDX_W'(1)) begin n_err++; $display("FAIL hold_retained got alloc_idx=%0d want 1", bus.alloc_idx); end
    bus.eu_ready = 1'b1;
    tick();
    n_cmp++; if (bus.issue_en !== 1'b1 || bus.issue_idx !== IDX_W'(0)) begin n_err++; $display("FAIL hold_release got en=%b idx=%0d want en=1 idx=0", bus.issue_en, bus.issue_idx); end
    tick();
  endtask

  task automatic test_flush();
    bus.eu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_instr(70 + i);
      bus.dispatch_en = 1'b1;
      tick();
    end
    n_cmp++; if (bus.alloc_idx !== IDX_W'(4)) begin n_err++; $display("FAIL flush_prefill got alloc_idx=%0d want 4", bus.alloc_idx); end
    set_instr(80);
    bus.flush    = 1'b1;
    bus.eu_ready = 1'b1;
    tick();
    bus.flush       = 1'b0;
    bus.dispatch_en = 1'b0;
    n_cmp++; if (bus.full !== 1'b0 || bus.alloc_idx !== IDX_W'(0) || bus.issue_en !== 1'b0) begin
      n_err++; $display("FAIL flush_clear got full=%b alloc_idx=%0d issue_en=%b want 0/0/0", bus.full, bus.alloc_idx, bus.issue_en);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.issue_en !== 1'b0) begin n_err++; $display("FAIL flush_no_issue cycle=%0d got %b want 0", i, bus.issue_en); end
    end
  endtask

  task automatic test_back_to_back();
    bus.eu_ready    = 1'b0;
    set_instr(60);
    bus.dispatch_en = 1'b1;
    push_exp(0, 60);
    tick();
    bus.eu_ready = 1'b1;
    set_instr(61);
    push_exp(1, 61);
    tick();
    bus.dispatch_en = 1'b0;
    n_cmp++; if (bus.issue_en !== 1'b1 || bus.issue_idx !== IDX_W'(0)) begin n_err++; $display("FAIL b2b_old_issue got en=%b idx=%0d want en=1 idx=0", bus.issue_en, bus.issue_idx); end
    n_cmp++; if (bus.alloc_idx !== IDX_W'(0)) begin n_err++; $display("FAIL b2b_new_in_slot1 got alloc_idx=%0d want 0", bus.alloc_idx); end
    tick();
    n_cmp++; if (bus.issue_en !== 1'b1 || bus.issue_idx !== IDX_W'(1)) begin n_err++; $display("FAIL b2b_new_issue got en=%b idx=%0d want en=1 idx=1", bus.issue_en, bus.issue_idx); end
    tick();
    n_cmp++; if (bus.issue_en !== 1'b0 || bus.alloc_idx !== IDX_W'(0)) begin n_err++; $display("FAIL b2b_idle got en=%b alloc_idx=%0d want en=0 alloc_idx=0", bus.issue_en, bus.alloc_idx); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_fill_and_drain();
    test_hold();
    test_flush();
    test_back_to_back();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
